// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned W_DEF = 32;
    localparam int unsigned N_DEF = 5;
    localparam int unsigned MAXP  = 32;

    typedef logic [W_DEF-1:0] data_t;
    typedef logic [N_DEF-1:0] addr_t;

    function automatic int unsigned nregs(input int unsigned n);
        return 32'(1) << n;
    endfunction

    // Index of the highest set bit; later write ports take priority.
    function automatic int unsigned prio_hi(input logic [MAXP-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAXP; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side bus of the register file.
interface regfile_mp_if #(
    parameter int unsigned W   = 32,
    parameter int unsigned N   = 5,
    parameter int unsigned NRD = 2,
    parameter int unsigned NWR = 1
);
    logic [NRD*N-1:0] rd_addr;
    logic [NRD*W-1:0] rd_data;
    logic [NRD-1:0]   rd_busy;
    logic [NWR-1:0]   wr_en;
    logic [NWR*N-1:0] wr_addr;
    logic [NWR*W-1:0] wr_data;
    logic [NWR-1:0]   wr_clr;
    logic             iss_valid;
    logic [N-1:0]     iss_rd;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_valid, iss_rd,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_valid, iss_rd,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/regfile_rdport.sv
// One read port: zero check, write/clear bypass and optional output register.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned N        = 5,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned RD_REG   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     addr,
    input  logic [W-1:0]     reg_val,
    input  logic             busy_val,
    input  logic [NWR-1:0]   wr_en,
    input  logic [NWR*N-1:0] wr_addr,
    input  logic [NWR*W-1:0] wr_data,
    input  logic [NWR-1:0]   wr_clr,
    input  logic             iss_valid,
    input  logic [N-1:0]     iss_rd,
    output logic [W-1:0]     data,
    output logic             busy
);

    logic [MAXP-1:0] wmatch;
    logic [MAXP-1:0] cmatch;
    logic [W-1:0]    data_c;
    logic            busy_c;

    always_comb begin
        wmatch = '0;
        cmatch = '0;
        for (int unsigned k = 0; k < NWR; k++) begin
            wmatch[k] = wr_en[k] && (wr_addr[k*N +: N] == addr);
            cmatch[k] = wmatch[k] && wr_clr[k];
        end
        data_c = reg_val;
        busy_c = busy_val;
        if (BYPASS != 0 && (|wmatch)) data_c = wr_data[prio_hi(wmatch)*W +: W];
        // A same-cycle issue to this register outranks the clearing write.
        if (BYPASS != 0 && (|cmatch) && !(iss_valid && iss_rd == addr)) busy_c = 1'b0;
        if (ZERO_REG != 0 && addr == '0) begin
            data_c = '0;
            busy_c = 1'b0;
        end
    end

    if (RD_REG != 0) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                data <= '0;
                busy <= 1'b0;
            end else begin
                data <= data_c;
                busy <= busy_c;
            end
        end
    end else begin : g_comb
        assign data = data_c;
        assign busy = busy_c;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with issue-side busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned N        = 5,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned RD_REG   = 1
) (
    input  logic       clk,
    input  logic       rst,
    regfile_mp_if.slave bus
);

    localparam int unsigned NR = nregs(N);

    if (NRD == 0 || NWR == 0) begin : g_bad_ports
        $error("regfile_mp: NRD and NWR must both be at least 1");
    end
    if (NWR > MAXP) begin : g_bad_nwr
        $error("regfile_mp: NWR exceeds the priority-select width");
    end

    logic [W-1:0]    regs [NR];
    logic [NR-1:0]   busy;
    logic [NWR-1:0]  wr_en_g;
    logic            iss_g;
    logic [MAXP-1:0] wmatch;
    logic [MAXP-1:0] cmatch;
    logic [NR-1:0]   wr_hit;
    logic [NR-1:0]   clr_hit;
    logic [NR-1:0]   set_hit;
    logic [W-1:0]    wr_val [NR];

    // Writes and issues presented during reset are discarded, including for bypass.
    assign wr_en_g = rst ? '0 : bus.wr_en;
    assign iss_g   = bus.iss_valid & ~rst;

    // Per-register write resolution and scoreboard set/clear.
    always_comb begin
        wmatch  = '0;
        cmatch  = '0;
        wr_hit  = '0;
        clr_hit = '0;
        set_hit = '0;
        for (int unsigned r = 0; r < NR; r++) begin
            wmatch = '0;
            cmatch = '0;
            for (int unsigned k = 0; k < NWR; k++) begin
                wmatch[k] = wr_en_g[k] && (bus.wr_addr[k*N +: N] == N'(r));
                cmatch[k] = wmatch[k] && bus.wr_clr[k];
            end
            wr_hit[r]  = (|wmatch) && !(ZERO_REG != 0 && r == 0);
            wr_val[r]  = bus.wr_data[prio_hi(wmatch)*W +: W];
            clr_hit[r] = |cmatch;
            set_hit[r] = iss_g && (bus.iss_rd == N'(r)) && !(ZERO_REG != 0 && r == 0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NR; r++) regs[r] <= '0;
            busy <= '0;
        end else begin
            for (int unsigned r = 0; r < NR; r++) begin
                if (wr_hit[r]) regs[r] <= wr_val[r];
                if (set_hit[r])      busy[r] <= 1'b1;
                else if (clr_hit[r]) busy[r] <= 1'b0;
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [N-1:0] a;
        assign a = bus.rd_addr[p*N +: N];

        regfile_rdport #(
            .W(W), .N(N), .NWR(NWR), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .RD_REG(RD_REG)
        ) u_rd (
            .clk       (clk),
            .rst       (rst),
            .addr      (a),
            .reg_val   (regs[a]),
            .busy_val  (busy[a]),
            .wr_en     (wr_en_g),
            .wr_addr   (bus.wr_addr),
            .wr_data   (bus.wr_data),
            .wr_clr    (bus.wr_clr),
            .iss_valid (iss_g),
            .iss_rd    (bus.iss_rd),
            .data      (bus.rd_data[p*W +: W]),
            .busy      (bus.rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations driven in lockstep against one reference model.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.W(32), .N(5), .NRD(2), .NWR(2)) ia ();
    regfile_mp_if #(.W(32), .N(5), .NRD(2), .NWR(2)) ib ();
    regfile_mp_if #(.W(32), .N(5), .NRD(2), .NWR(2)) ic ();

    regfile_mp #(.W(32), .N(5), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1), .RD_REG(0))
        u_a (.clk(clk), .rst(rst), .bus(ia));
    regfile_mp #(.W(32), .N(5), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0), .RD_REG(0))
        u_b (.clk(clk), .rst(rst), .bus(ib));
    regfile_mp #(.W(32), .N(5), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1), .RD_REG(1))
        u_c (.clk(clk), .rst(rst), .bus(ic));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // current stimulus
    logic        t_rst;
    logic [1:0]  t_we, t_clr;
    logic [4:0]  t_wa [2];
    logic [31:0] t_wd [2];
    logic        t_iss;
    logic [4:0]  t_issrd;
    logic [4:0]  t_ra [2];

    // reference architectural state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [31:0] exp_c_d [2];
    bit          exp_c_b [2];

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  clr;
        logic        iss;
        logic [4:0]  issrd;
        logic [4:0]  ra0;
        int          sel;
        logic [31:0] ed;
        logic        eb;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(input logic r, input logic [1:0] we, input logic [4:0] wa0,
                                input logic [31:0] wd0, input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic [1:0] clr, input logic iss, input logic [4:0] issrd,
                                input logic [4:0] ra0, input int sel, input logic [31:0] ed,
                                input logic eb);
        vec_t v;
        v.rst = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.clr = clr; v.iss = iss; v.issrd = issrd; v.ra0 = ra0; v.sel = sel; v.ed = ed; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] eff_we();
        return t_rst ? 2'b00 : t_we;
    endfunction

    // Value a read port sees before its latency stage.
    function automatic logic [31:0] pre_data(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        logic [1:0]  we;
        we = eff_we();
        v  = m_regs[a];
        if (byp) for (int k = 0; k < 2; k++) if (we[k] && t_wa[k] == a) v = t_wd[k];
        if (a == 5'd0) v = 32'd0;
        return v;
    endfunction

    function automatic bit pre_busy(input logic [4:0] a, input bit byp);
        bit b, cl, iss_hit;
        logic [1:0] we;
        we = eff_we();
        b  = m_busy[a];
        cl = 1'b0;
        for (int k = 0; k < 2; k++) if (we[k] && t_clr[k] && t_wa[k] == a) cl = 1'b1;
        iss_hit = !t_rst && t_iss && t_issrd == a;
        if (byp && cl && !iss_hit) b = 1'b0;
        if (a == 5'd0) b = 1'b0;
        return b;
    endfunction

    task automatic model_update();
        bit setr, clr;
        if (t_rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'd0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                setr = t_iss && t_issrd == 5'(r) && r != 0;
                clr  = 1'b0;
                for (int k = 0; k < 2; k++)
                    if (t_we[k] && t_clr[k] && t_wa[k] == 5'(r)) clr = 1'b1;
                if (setr) m_busy[r] = 1'b1;
                else if (clr) m_busy[r] = 1'b0;
            end
            for (int k = 0; k < 2; k++)
                if (t_we[k] && t_wa[k] != 5'd0) m_regs[t_wa[k]] = t_wd[k];
        end
    endtask

    task automatic drive();
        rst = t_rst;
        ia.rd_addr = {t_ra[1], t_ra[0]}; ib.rd_addr = {t_ra[1], t_ra[0]}; ic.rd_addr = {t_ra[1], t_ra[0]};
        ia.wr_en = t_we;   ib.wr_en = t_we;   ic.wr_en = t_we;
        ia.wr_clr = t_clr; ib.wr_clr = t_clr; ic.wr_clr = t_clr;
        ia.wr_addr = {t_wa[1], t_wa[0]}; ib.wr_addr = {t_wa[1], t_wa[0]}; ic.wr_addr = {t_wa[1], t_wa[0]};
        ia.wr_data = {t_wd[1], t_wd[0]}; ib.wr_data = {t_wd[1], t_wd[0]}; ic.wr_data = {t_wd[1], t_wd[0]};
        ia.iss_valid = t_iss; ib.iss_valid = t_iss; ic.iss_valid = t_iss;
        ia.iss_rd = t_issrd;  ib.iss_rd = t_issrd;  ic.iss_rd = t_issrd;
    endtask

    // One clock: drive, check all configs against the model (plus optional vector), advance.
    task automatic step(input bit vchk, input int sel, input logic [31:0] vd, input logic vb,
                        input int idx);
        logic [31:0] nd [2];
        bit          nb [2];
        logic [31:0] ad, adv;
        logic        ab;
        @(negedge clk);
        drive();
        #1;
        if (chk_en) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("a_data p%0d", p), ia.rd_data[p*32 +: 32], pre_data(t_ra[p], 1'b1));
                chk($sformatf("a_busy p%0d", p), 32'(ia.rd_busy[p]), 32'(pre_busy(t_ra[p], 1'b1)));
                chk($sformatf("b_data p%0d", p), ib.rd_data[p*32 +: 32], pre_data(t_ra[p], 1'b0));
                chk($sformatf("b_busy p%0d", p), 32'(ib.rd_busy[p]), 32'(pre_busy(t_ra[p], 1'b0)));
                chk($sformatf("c_data p%0d", p), ic.rd_data[p*32 +: 32], exp_c_d[p]);
                chk($sformatf("c_busy p%0d", p), 32'(ic.rd_busy[p]), 32'(exp_c_b[p]));
            end
        end
        if (vchk) begin
            ad = (sel == 0) ? ia.rd_data[31:0] : (sel == 1) ? ib.rd_data[31:0] : ic.rd_data[31:0];
            ab = (sel == 0) ? ia.rd_busy[0]    : (sel == 1) ? ib.rd_busy[0]    : ic.rd_busy[0];
            adv = ad;
            chk($sformatf("vec%0d data", idx), adv, vd);
            chk($sformatf("vec%0d busy", idx), 32'(ab), 32'(vb));
        end
        for (int p = 0; p < 2; p++) begin
            nd[p] = t_rst ? 32'd0 : pre_data(t_ra[p], 1'b1);
            nb[p] = t_rst ? 1'b0  : pre_busy(t_ra[p], 1'b1);
        end
        @(posedge clk);
        model_update();
        for (int p = 0; p < 2; p++) begin
            exp_c_d[p] = nd[p];
            exp_c_b[p] = nb[p];
        end
    endtask

    task automatic idle_inputs();
        t_rst = 1'b0; t_we = 2'b00; t_clr = 2'b00; t_iss = 1'b0; t_issrd = 5'd0;
        t_wa[0] = 5'd0; t_wa[1] = 5'd0; t_wd[0] = 32'd0; t_wd[1] = 32'd0;
        t_ra[0] = 5'd0; t_ra[1] = 5'd9;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'd0;
            m_busy[r] = 1'b0;
        end
        exp_c_d[0] = 32'd0; exp_c_d[1] = 32'd0;
        exp_c_b[0] = 1'b0;  exp_c_b[1] = 1'b0;

        //           rst we    wa0   wd0           wa1   wd1     clr   iss issrd ra0  sel ed            eb
        vecs[0]  = mk(0, 2'b01, 5'd5, 32'hDEAD,     5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd5, 0, 32'hDEAD,     0);
        vecs[1]  = mk(1, 2'b01, 5'd5, 32'h1111,     5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd5, 0, 32'hDEAD,     0);
        vecs[2]  = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd5, 2, 32'h0,        0);
        vecs[3]  = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd5, 0, 32'h0,        0);
        vecs[4]  = mk(0, 2'b01, 5'd0, 32'h1234,     5'd0, 32'h0,  2'b00, 1, 5'd0, 5'd0, 0, 32'h0,        0);
        vecs[5]  = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd0, 2, 32'h0,        0);
        vecs[6]  = mk(0, 2'b01, 5'd3, 32'hA5A5,     5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd3, 1, 32'h0,        0);
        vecs[7]  = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd3, 1, 32'hA5A5,     0);
        vecs[8]  = mk(0, 2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 2'b00, 0, 5'd0, 5'd7, 0, 32'h22,       0);
        vecs[9]  = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd7, 1, 32'h22,       0);
        vecs[10] = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 1, 5'd9, 5'd9, 0, 32'h0,        0);
        vecs[11] = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd9, 0, 32'h0,        1);
        vecs[12] = mk(0, 2'b10, 5'd0, 32'h0,        5'd9, 32'h99, 2'b10, 0, 5'd0, 5'd9, 0, 32'h99,       0);
        vecs[13] = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd9, 1, 32'h99,       0);
        vecs[14] = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 1, 5'd9, 5'd9, 0, 32'h99,       0);
        vecs[15] = mk(0, 2'b01, 5'd9, 32'hAB,       5'd0, 32'h0,  2'b01, 1, 5'd9, 5'd9, 0, 32'hAB,       1);
        vecs[16] = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd9, 0, 32'hAB,       1);
        vecs[17] = mk(0, 2'b01, 5'd9, 32'hCD,       5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd9, 0, 32'hCD,       1);
        vecs[18] = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd9, 1, 32'hCD,       1);
        vecs[19] = mk(0, 2'b01, 5'd4, 32'h55,       5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd4, 0, 32'h55,       0);
        vecs[20] = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd4, 0, 32'h55,       0);
        vecs[21] = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd5, 2, 32'h55,       0);
        vecs[22] = mk(0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 0, 5'd0, 5'd5, 2, 32'h0,        0);

        idle_inputs();
        t_rst = 1'b1;
        step(1'b0, 0, 32'd0, 1'b0, -1);
        step(1'b0, 0, 32'd0, 1'b0, -1);
        chk_en = 1'b1;

        // reset state: everything reads zero and idle
        idle_inputs();
        t_ra[0] = 5'd5;
        step(1'b1, 2, 32'd0, 1'b0, 100);

        for (int i = 0; i < 23; i++) begin
            idle_inputs();
            t_rst = vecs[i].rst; t_we = vecs[i].we; t_clr = vecs[i].clr;
            t_wa[0] = vecs[i].wa0; t_wd[0] = vecs[i].wd0;
            t_wa[1] = vecs[i].wa1; t_wd[1] = vecs[i].wd1;
            t_iss = vecs[i].iss; t_issrd = vecs[i].issrd; t_ra[0] = vecs[i].ra0;
            step(1'b1, vecs[i].sel, vecs[i].ed, vecs[i].eb, i);
        end

        // hand sequence: reset mid-operation with a pending issue; registered port is 0 after
        idle_inputs();
        t_we = 2'b01; t_wa[0] = 5'd6; t_wd[0] = 32'h6666;
        step(1'b0, 0, 32'd0, 1'b0, -1);
        idle_inputs();
        t_rst = 1'b1; t_iss = 1'b1; t_issrd = 5'd6; t_ra[0] = 5'd6;
        step(1'b0, 0, 32'd0, 1'b0, -1);
        idle_inputs();
        t_ra[0] = 5'd6;
        step(1'b1, 2, 32'd0, 1'b0, 200);
        step(1'b1, 0, 32'd0, 1'b0, 201);

        // randomized traffic, addresses squeezed to force collisions
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            t_rst   = ($urandom_range(0, 59) == 0);
            t_we    = 2'($urandom_range(0, 3));
            t_clr   = 2'($urandom_range(0, 3));
            t_wa[0] = 5'($urandom_range(0, 11));
            t_wa[1] = 5'($urandom_range(0, 11));
            t_wd[0] = $urandom;
            t_wd[1] = $urandom;
            t_iss   = 1'($urandom_range(0, 1));
            t_issrd = 5'($urandom_range(0, 11));
            t_ra[0] = 5'($urandom_range(0, 11));
            t_ra[1] = ($urandom_range(0, 3) == 0) ? t_wa[1] : 5'($urandom_range(0, 31));
            step(1'b0, 0, 32'd0, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
